// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types and constants for the iterative multiply/divide
//               unit: funct3 operation codes, sequencer states, writeback
//               select codes and a word-mode sign-extension helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // funct3 encodings of the RV64M operations
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    // Writeback mux select codes (shared with the writeback stage decoder)
    localparam logic [2:0] RDSEL_ALU  = 3'd0;
    localparam logic [2:0] RDSEL_DMEM = 3'd4;
    localparam logic [2:0] RDSEL_DIV  = 3'd5;
    localparam logic [2:0] RDSEL_REM  = 3'd6;
    localparam logic [2:0] RDSEL_MUL  = 3'd7;

    // Sign-extend the low 32 bits of a 64-bit value
    function automatic logic [63:0] sext_word(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_fix.sv
`default_nettype none
// ============================================================================
// Module      : mdu_fix
// Description : Combinational result correction for the multiply/divide unit.
//               Applies the latched sign fixup to the raw magnitude result and
//               performs word-mode truncation and sign-extension.
// Ports       : is_div  - operation is a divide/remainder
//               is_rem  - remainder selected (divides only)
//               mul_hi  - high half of the product selected (multiplies only)
//               word    - W variant
//               neg     - negate product/quotient
//               neg_r   - negate remainder
//               hi, lo  - raw datapath registers (product or remainder/quotient)
//               result  - corrected 64-bit result
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_fix
    import mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            is_div,
    input  logic            is_rem,
    input  logic            mul_hi,
    input  logic            word,
    input  logic            neg,
    input  logic            neg_r,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] result
);

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_sel;

    always_comb begin
        w_prod = neg   ? -{hi, lo} : {hi, lo};
        w_quo  = neg   ? -lo : lo;
        w_rem  = neg_r ? -hi : hi;
        w_sel  = '0;
        if (is_div) begin
            w_sel = is_rem ? w_rem : w_quo;
        end else if (word) begin
            // A 32-iteration shift-right multiply leaves the product shifted
            // up by 32, so its low word sits in lo[63:32].
            w_sel = {{(XLEN/2){1'b0}}, lo[XLEN-1:XLEN/2]};
        end else begin
            w_sel = mul_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
        end
        result = word ? sext_word(w_sel) : w_sel;
    end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : Sequencer for the radix-2 iterative RV64M multiply/divide
//               unit. One operation at a time; shift-add multiply, restoring
//               divide, RISC-V divide special cases, valid/ready result port.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               in_valid/in_ready    - request handshake (ready only in IDLE)
//               op, word             - funct3 and W-variant flag
//               src_a, src_b         - rs1, rs2 operands
//               flush                - abort current operation
//               out_valid/out_ready  - result handshake
//               result               - 64-bit result
//               rd_sel               - writeback mux select
//               stall                - pipeline stall request
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [2:0]      rd_sel,
    output logic            stall
);

    mdu_state_e      r_state;
    mdu_op_e         r_op;
    logic            r_word;
    logic            r_neg;
    logic            r_neg_r;
    logic [6:0]      r_cnt;
    logic [XLEN-1:0] r_hi;   // product high half / remainder
    logic [XLEN-1:0] r_lo;   // product low half + multiplier / quotient + dividend
    logic [XLEN-1:0] r_b;    // multiplicand / divisor

    // ---------------- request decode ----------------
    mdu_op_e         w_op;
    logic            w_sgn_a, w_sgn_b, w_sa, w_sb;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_abs_a, w_abs_b, w_dividend;
    logic            w_b_zero, w_a_min, w_ovf, w_special;

    always_comb begin
        w_op = mdu_op_e'(op);
        // Word forms of MULH* do not exist; treat them as MULW.
        if (word && (op != 3'd0) && !op[2]) begin
            w_op = OP_MUL;
        end
        w_sgn_a = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                  (w_op == OP_DIV)  || (w_op == OP_REM);
        w_sgn_b = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
        if (word) begin
            w_a_ext = w_sgn_a ? sext_word(src_a) : {32'd0, src_a[31:0]};
            w_b_ext = w_sgn_b ? sext_word(src_b) : {32'd0, src_b[31:0]};
        end else begin
            w_a_ext = src_a;
            w_b_ext = src_b;
        end
        w_sa    = w_sgn_a & w_a_ext[XLEN-1];
        w_sb    = w_sgn_b & w_b_ext[XLEN-1];
        w_abs_a = w_sa ? -w_a_ext : w_a_ext;
        w_abs_b = w_sb ? -w_b_ext : w_b_ext;
        // Word dividends are pre-shifted so the 32 iterations consume their bits.
        w_dividend = word ? {w_abs_a[31:0], 32'd0} : w_abs_a;
        w_b_zero   = (w_b_ext == '0);
        w_a_min    = word ? (w_a_ext[31:0] == 32'h8000_0000)
                          : (w_a_ext == {1'b1, {(XLEN-1){1'b0}}});
        w_ovf      = !w_op[0] && w_a_min && (w_b_ext == '1);
        w_special  = w_op[2] && (w_b_zero || w_ovf);
    end

    // ---------------- iteration datapath ----------------
    logic [XLEN:0] w_sum;    // multiply partial sum with carry
    logic [XLEN:0] w_shift;  // divide: remainder shifted with next dividend bit
    logic [XLEN:0] w_diff;
    logic          w_ge;

    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_b};
        w_ge    = !w_diff[XLEN];
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_MUL;
            r_word  <= 1'b0;
            r_neg   <= 1'b0;
            r_neg_r <= 1'b0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op   <= w_op;
                        r_word <= word;
                        if (w_special) begin
                            // Final values loaded unsigned so the fixup passes them through.
                            r_lo    <= w_b_zero ? '1 : w_a_ext;
                            r_hi    <= w_b_zero ? w_a_ext : '0;
                            r_neg   <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_hi    <= '0;
                            r_lo    <= w_op[2] ? w_dividend : w_abs_b;
                            r_b     <= w_op[2] ? w_abs_b : w_abs_a;
                            r_neg   <= w_sa ^ w_sb;
                            r_neg_r <= w_sa;
                            r_cnt   <= word ? 7'd32 : 7'd64;
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 7'd1;
                    if (r_op[2]) begin
                        r_hi <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_ge};
                    end else begin
                        r_hi <= w_sum[XLEN:1];
                        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                    end
                    if (r_cnt == 7'd1) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- outputs ----------------
    logic [XLEN-1:0] w_fixed;

    mdu_fix #(.XLEN(XLEN)) u_fix (
        .is_div (r_op[2]),
        .is_rem (r_op[1]),
        .mul_hi (r_op != OP_MUL),
        .word   (r_word),
        .neg    (r_neg),
        .neg_r  (r_neg_r),
        .hi     (r_hi),
        .lo     (r_lo),
        .result (w_fixed)
    );

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        stall     = (in_valid && !in_ready) || (r_state == ST_BUSY);
        result    = out_valid ? w_fixed : '0;
        if (!out_valid) begin
            rd_sel = RDSEL_ALU;
        end else if (!r_op[2]) begin
            rd_sel = RDSEL_MUL;
        end else begin
            rd_sel = r_op[1] ? RDSEL_REM : RDSEL_DIV;
        end
    end

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencer for the iterative multiply/divide unit (RV64M, including the W variants). Accepts one operation at a time from execute and runs a radix-2 shift-add multiply or shift-subtract divide. Handles the RISC-V divide-by-zero and overflow special cases and returns a 64-bit result with a valid/ready handshake. Also drives the 3-bit writeback-select code for the writeback result mux and the pipeline stall condition.

## Interface
Parameters:
- `XLEN`, 64: operand/result width; only 64 supported.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `op` in 3: funct3. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `word` in 1: W variant (MULW/DIVW/DIVUW/REMW/REMUW); `word` with op 1–3 is illegal and treated as op 0.
- `src_a`, `src_b` in 64: rs1, rs2.
- `flush` in 1: abort the current operation.
- `out_valid` out 1: result available.
- `out_ready` in 1: writeback consumes the result.
- `result` out 64: final result.
- `rd_sel` out 3: writeback select. 7 for MUL*, 5 for DIV/DIVU, 6 for REM/REMU; 0 when `out_valid`=0.
- `stall` out 1: `in_valid & ~in_ready`, or BUSY.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE → BUSY on `in_valid & in_ready`, except for the special divides below.
  - On accept, latch `op`, `word`, operand signs and absolute values.
  - Load iteration counter N: 64, or 32 if `word`.
- Special divides go IDLE → DONE directly:
  - Divisor zero: quotient all-ones; remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = −1): quotient = dividend; remainder = 0.
  - In word mode, both checks apply to the low 32 bits, and results are sign-extended from bit 31.
- BUSY: one iteration per cycle; counter decrements; → DONE when counter reaches 1.
  - Multiply: 128-bit accumulate. MUL returns the low 64 bits. MULH/MULHSU/MULHU return the high 64 bits.
  - Divide: restoring algorithm, 64-bit remainder register, one quotient bit per cycle.
- DONE: `out_valid`=1; `result` and `rd_sel` are stable.
  - Sign fixup is applied combinationally from the latched signs: quotient negated iff the operand signs differ; remainder takes the dividend's sign.
  - → IDLE on `out_ready`. No new request is accepted in that same cycle.
- Word mode:
  - Operands are the low 32 bits, sign-extended (signed ops) or zero-extended (DIVUW/REMUW).
  - Result is the low 32 bits, sign-extended to 64.
- `flush`: any state → IDLE next cycle; a pending result is dropped. `flush` has priority over `out_ready` and over accept.

## Timing
- Reset: state IDLE; `in_ready`=1; `out_valid`=0; `result`=0; `rd_sel`=0; `stall`=0; counter and data registers 0.
- Normal latency:
  - Request accepted at edge T.
  - `out_valid` rises in cycle T+N+1 (N = 64 or 32).
- Special divide latency: `out_valid` rises in cycle T+1.
- Throughput: after the `out_ready` handshake at edge D, the next accept is possible at edge D+1.
- `out_valid` is held with `result`/`rd_sel` stable until `out_ready`; any backpressure duration is allowed.
- `reset` mid-operation: identical to power-on reset; no output is produced.
- Simultaneous `flush` and `in_valid` in IDLE: the request is not accepted.

## Structure
- Shared package `mdu_pkg`:
  - `mdu_op_e` enum (funct3 codes).
  - State enum.
  - Writeback-select constants: `RDSEL_ALU`=0, `RDSEL_DMEM`=4, `RDSEL_DIV`=5, `RDSEL_REM`=6, `RDSEL_MUL`=7.
  - These are the same codes decoded by the writeback mux.
- Sub-module `mdu_fix`: combinational sign correction plus word-mode truncation/sign-extension of the raw result.
- FSM, counter and iteration datapath live in `mdu_ctrl`.

## Test plan
- DIV 100 / −7 → `result`=−14 (0xFFFF_FFFF_FFFF_FFF2), `rd_sel`=5, `out_valid` at T+65; REM same operands → 2, `rd_sel`=6.
- DIVU x / 0 → 0xFFFF_FFFF_FFFF_FFFF at T+1; REM 0x8000_0000_0000_0000 / −1 → 0 at T+1; DIVW 0x8000_0000 / −1 → 0xFFFF_FFFF_8000_0000.
- MULH −1 × −1 → 0 with MUL → 1; MULHU 0xFFFF…F × 2 → 1; MULW 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE at T+33.
- Backpressure: `out_ready` low for 10 cycles → `result` stable, `in_ready`=0, `stall`=1; a new request is accepted the cycle after the handshake.
- `flush` at T+20 of a DIV → IDLE at T+21, no `out_valid`; a following MUL 3×5 → 15 at the correct latency.
- `reset` asserted during BUSY → all outputs return to reset values next cycle.
